hm_lane_merge: RTL and testbench

Four-lane to one-lane merge stage: the receiving end of the 1-to-4 lane fan-out used around the HM_100x400_4x4 / HM_100x100_1x1 macro groups in the placement testcases. It buffers each incoming lane in a small FIFO and drains the lanes round-robin onto a single valid/ready output stream, tagging each word with its source lane. It gives the mpl2 testcases a fan-in block with real sequential state, so the placer has both ends of a lane group to cluster.

---
 rtl/hm_lane_merge.sv | 82 ++++++++
 tb/tb_hm_lane_merge.sv | 135 +++++++++++++
 2 files changed

// File: rtl/hm_lane_merge.sv
// hm_lane_merge: four per-lane FIFOs drained round-robin onto one registered valid/ready stream tagged with the source lane
module hm_lane_merge #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            in_valid,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic [3:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_lane,
  input  logic                  out_ready
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [4][DEPTH];
  logic [DATA_W-1:0] mem_d [4][DEPTH];
  logic [AW-1:0]     wr_q [4], wr_d [4], rd_q [4], rd_d [4];
  logic [AW:0]       cnt_q [4], cnt_d [4];
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_lane_q, out_lane_d;
  logic [1:0]        rr_q, rr_d;
  logic              free, grant;
  logic [1:0]        gl, lane;
  logic [3:0]        push, pop;
  always_comb begin
    free  = !out_valid_q | out_ready;
    grant = 1'b0;
    gl    = rr_q;
    lane  = rr_q;
    // scan from farthest to nearest so the lane closest to rr_ptr wins
    for (int k = 3; k >= 0; k--) begin
      lane = rr_q + 2'(k);
      if (cnt_q[lane] != '0) begin
        grant = free;
        gl    = lane;
      end
    end
    mem_d = mem_q;
    for (int i = 0; i < 4; i++) begin
      in_ready[i] = cnt_q[i] != (AW+1)'(DEPTH);
      push[i]     = in_valid[i] & in_ready[i];
      pop[i]      = grant & (gl == 2'(i));
      wr_d[i]     = push[i] ? wr_q[i] + 1'b1 : wr_q[i];
      rd_d[i]     = pop[i] ? rd_q[i] + 1'b1 : rd_q[i];
      cnt_d[i]    = cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      if (push[i]) mem_d[i][wr_q[i]] = in_data[i*DATA_W +: DATA_W];
    end
    out_valid_d = free ? grant : out_valid_q;
    out_data_d  = grant ? mem_q[gl][rd_q[gl]] : out_data_q;
    out_lane_d  = grant ? gl : out_lane_q;
    rr_d        = grant ? gl + 2'd1 : rr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
        for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      rr_q        <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      rr_q        <= rr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
endmodule

// File: tb/tb_hm_lane_merge.sv
// tb_hm_lane_merge: directed checks of reset, latency, round-robin, backpressure, wrap and push/pop overlap
module tb_hm_lane_merge;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_lane;
  logic        out_ready;
  int          n_cmp = 0;
  int          n_err = 0;
  hm_lane_merge #(.DATA_W(8), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_lane(out_lane), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic chk_out(input string tag, input logic [7:0] d, input logic [1:0] l);
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
    chk({tag, "_d"}, 32'(out_data), 32'(d));
    chk({tag, "_l"}, 32'(out_lane), 32'(l));
  endtask
  logic [7:0] rr_exp [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_lane", 32'(out_lane), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'hF);
    @(negedge clk); rst = 1'b0;
    // reset mid-stream: FIFO 2 holds two words, output register busy
    in_valid = 4'b0100; in_data[16 +: 8] = 8'h2A; tick();
    in_data[16 +: 8] = 8'h2B; tick();
    in_data[16 +: 8] = 8'h2C; tick();
    in_valid = '0;
    chk("pre_valid", 32'(out_valid), 32'd1);
    chk("pre_ready", 32'(in_ready), 32'hB);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_lane", 32'(out_lane), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'hF);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_stale", 32'(out_valid), 32'd0);
    end
    // single lane latency and order
    in_valid = 4'b0010; in_data[8 +: 8] = 8'h11; tick();
    in_data[8 +: 8] = 8'h12; tick();
    in_valid = '0;
    chk_out("lat_w0", 8'h11, 2'd1);
    tick();
    chk_out("lat_w1", 8'h12, 2'd1);
    tick();
    chk("lat_empty", 32'(out_valid), 32'd0);
    // round-robin fairness from rr_ptr=0
    do_reset();
    in_valid = 4'hF; in_data = 32'hA3A2A1A0; tick();
    in_data = 32'hB3B2B1B0; tick();
    in_valid = '0;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("rr%0d", i), rr_exp[i], 2'(i % 4));
      tick();
    end
    chk("rr_empty", 32'(out_valid), 32'd0);
    // backpressure and full on lane 3 (rr_ptr is 0 here)
    out_ready = 1'b0;
    in_valid = 4'b1000; in_data[24 +: 8] = 8'h31; tick();
    in_data[24 +: 8] = 8'h32; tick();
    chk_out("bp_first", 8'h31, 2'd3);
    in_data[24 +: 8] = 8'h33; tick();
    chk("bp_full", 32'(in_ready), 32'h7);
    in_data[24 +: 8] = 8'h34; tick();
    chk("bp_still_full", 32'(in_ready), 32'h7);
    chk_out("bp_hold", 8'h31, 2'd3);
    in_valid = '0; out_ready = 1'b1; tick();
    chk_out("bp_drain0", 8'h32, 2'd3);
    chk("bp_ready_back", 32'(in_ready), 32'hF);
    tick();
    chk_out("bp_drain1", 8'h33, 2'd3);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    // pointer wrap and skip
    do_reset();
    out_ready = 1'b0;
    in_valid = 4'b0100; in_data[16 +: 8] = 8'h21; tick();
    in_valid = 4'b0101; in_data[0 +: 8] = 8'h01; in_data[16 +: 8] = 8'h22; tick();
    in_valid = '0;
    chk_out("wrap_l2", 8'h21, 2'd2);
    out_ready = 1'b1; tick();
    chk_out("wrap_l0", 8'h01, 2'd0);
    tick();
    chk_out("wrap_l2b", 8'h22, 2'd2);
    tick();
    chk("wrap_empty", 32'(out_valid), 32'd0);
    // simultaneous push and pop on lane 0
    do_reset();
    out_ready = 1'b0;
    in_valid = 4'b0001; in_data[0 +: 8] = 8'h50; tick();
    in_data[0 +: 8] = 8'h51; tick();
    chk_out("pp_hold", 8'h50, 2'd0);
    out_ready = 1'b1; in_data[0 +: 8] = 8'h55; tick();
    in_valid = '0;
    chk_out("pp_pop", 8'h51, 2'd0);
    chk("pp_ready", 32'(in_ready), 32'hF);
    tick();
    chk_out("pp_new", 8'h55, 2'd0);
    tick();
    chk("pp_empty", 32'(out_valid), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
